// File: rtl/seq_divider_if.sv
// Divider request/response bundle: operands go in with start, results and status come back with done.
// Handshake: start is a request accepted on a rising clk edge when the unit is not busy
// (IDLE or DONE). Requests while busy are dropped. done pulses once per accepted request,
// and results and status stay valid from done until the next accepted start.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// Self-sequenced non-restoring divider: one quotient bit per cycle, signed/unsigned mode,
// plus single-cycle handling of divide-by-zero and signed MIN/-1 overflow.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  dif,
  output logic [1:0]    state_o
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH:0]   d_q;
  logic             neg_q_q, neg_r_q;
  logic             busy_q, done_q, dbz_q, ovf_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  logic             accept, sign_a, sign_b, is_zero, is_ovf;
  logic [WIDTH-1:0] mag_a, mag_b, q_final, r_final;
  logic [WIDTH:0]   shifted, r_step, r_fix;

  always_comb begin
    accept  = 1'b0;
    sign_a  = 1'b0;
    sign_b  = 1'b0;
    mag_a   = '0;
    mag_b   = '0;
    is_zero = 1'b0;
    is_ovf  = 1'b0;
    shifted = '0;
    r_step  = '0;
    r_fix   = '0;
    q_final = '0;
    r_final = '0;

    accept  = dif.start && (state_q == S_IDLE || state_q == S_DONE);
    sign_a  = dif.signed_mode & dif.dividend[WIDTH-1];
    sign_b  = dif.signed_mode & dif.divisor[WIDTH-1];
    // Negating MIN yields MIN, whose unsigned reading is the correct magnitude.
    mag_a   = sign_a ? -dif.dividend : dif.dividend;
    mag_b   = sign_b ? -dif.divisor  : dif.divisor;
    is_zero = (dif.divisor == '0);
    is_ovf  = dif.signed_mode && (dif.dividend == MIN_VAL) && (dif.divisor == '1);

    // The shift drops r_q's sign bit; modular WIDTH+1 arithmetic still lands in range.
    shifted = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    r_step  = r_q[WIDTH] ? (shifted + d_q) : (shifted - d_q);
    r_fix   = r_q[WIDTH] ? (r_q + d_q) : r_q;
    q_final = neg_q_q ? -q_q : q_q;
    r_final = neg_r_q ? -r_fix[WIDTH-1:0] : r_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
          if (accept) begin
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
            if (is_zero) begin
              quot_q  <= '1;
              rem_q   <= dif.dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (is_ovf) begin
              quot_q  <= MIN_VAL;
              rem_q   <= '0;
              ovf_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              q_q     <= mag_a;
              r_q     <= '0;
              d_q     <= {1'b0, mag_b};
              neg_q_q <= sign_a ^ sign_b;
              neg_r_q <= sign_a;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_q   <= r_step;
          q_q   <= {q_q[WIDTH-2:0], ~r_step[WIDTH]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_q <= S_FIX;
        end
        S_FIX: begin
          quot_q  <= q_final;
          rem_q   <= r_final;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dif.busy        = busy_q;
  assign dif.done        = done_q;
  assign dif.quotient    = quot_q;
  assign dif.remainder   = rem_q;
  assign dif.div_by_zero = dbz_q;
  assign dif.overflow    = ovf_q;
  assign state_o         = state_q;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: 8-bit and 16-bit instances checked against an integer-arithmetic model.
module tb_seq_divider;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(8))  dif8();
  seq_divider_if #(.WIDTH(16)) dif16();
  logic [1:0] st8, st16;

  seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .dif(dif8),  .state_o(st8));
  seq_divider #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .dif(dif16), .state_o(st16));

  int checks   = 0;
  int failures = 0;
  logic [33:0] exp_q[$]; // {div_by_zero, overflow, remainder, quotient}

  initial begin
    #1ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Reference: plain integer division; SV '/' and '%' truncate toward zero.
  function automatic void model(input int w, input bit sm, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r, output bit dz, output bit ov);
    longint one, mask, sa, sb;
    one  = 1;
    mask = (one << w) - 1;
    sa   = longint'(a) & mask;
    sb   = longint'(b) & mask;
    if (sm && sa >= (one << (w - 1))) sa = sa - (one << w);
    if (sm && sb >= (one << (w - 1))) sb = sb - (one << w);
    dz = 1'b0;
    ov = 1'b0;
    if (sb == 0) begin
      q = 16'(mask); r = 16'(sa & mask); dz = 1'b1;
    end else if (sm && sa == -(one << (w - 1)) && sb == -1) begin
      q = 16'(one << (w - 1)); r = 16'h0; ov = 1'b1;
    end else begin
      q = 16'((sa / sb) & mask);
      r = 16'((sa % sb) & mask);
    end
  endfunction

  task automatic drive(input int w, input bit st, input bit sm, input logic [15:0] a, input logic [15:0] b);
    if (w == 8) begin
      dif8.start = st; dif8.signed_mode = sm; dif8.dividend = a[7:0]; dif8.divisor = b[7:0];
    end else begin
      dif16.start = st; dif16.signed_mode = sm; dif16.dividend = a; dif16.divisor = b;
    end
  endtask

  // {busy, done, div_by_zero, overflow, remainder, quotient}
  function automatic logic [35:0] obs(input int w);
    if (w == 8)
      return {dif8.busy, dif8.done, dif8.div_by_zero, dif8.overflow,
              8'h00, dif8.remainder, 8'h00, dif8.quotient};
    return {dif16.busy, dif16.done, dif16.div_by_zero, dif16.overflow, dif16.remainder, dif16.quotient};
  endfunction

  // One request: pulse start, scramble inputs afterwards, then time and check the result.
  task automatic run_op(input int w, input bit sm, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input bit edz, input bit eov,
                        input string nm);
    int lat, bsy, exp_lat, exp_bsy;
    bit got;
    logic [33:0] e;
    logic [35:0] o;
    exp_q.push_back({edz, eov, er, eq});
    @(negedge clk);
    drive(w, 1'b1, sm, a, b);
    @(negedge clk);
    drive(w, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    lat = 0; bsy = 0; got = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      o = obs(w);
      if (o[35]) bsy++;
      if (o[34]) begin got = 1'b1; lat = k; break; end
      @(negedge clk);
    end
    e = exp_q.pop_front();
    exp_lat = (e[33] || e[32]) ? 1 : w + 2;
    exp_bsy = (e[33] || e[32]) ? 0 : w + 1;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s done_timeout got=none exp=%0d", nm, exp_lat);
      return;
    end
    if (lat !== exp_lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", nm, lat, exp_lat); end
    checks++;
    if (bsy !== exp_bsy) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", nm, bsy, exp_bsy); end
    checks++;
    if (o[15:0] !== e[15:0]) begin failures++; $display("FAIL %s quotient got=%h exp=%h", nm, o[15:0], e[15:0]); end
    checks++;
    if (o[31:16] !== e[31:16]) begin failures++; $display("FAIL %s remainder got=%h exp=%h", nm, o[31:16], e[31:16]); end
    checks++;
    if (o[33:32] !== e[33:32]) begin failures++; $display("FAIL %s dbz_ovf got=%b exp=%b", nm, o[33:32], e[33:32]); end
    @(negedge clk);
    o = obs(w);
    checks++;
    if (o[34] !== 1'b0) begin failures++; $display("FAIL %s done_pulse got=%b exp=0", nm, o[34]); end
  endtask

  task automatic check_cleared(input string nm);
    logic [35:0] o8, o16;
    o8  = obs(8);
    o16 = obs(16);
    checks++;
    if (o8 !== 36'h0 || o16 !== 36'h0 || st8 !== 2'd0 || st16 !== 2'd0) begin
      failures++;
      $display("FAIL %s outputs got=%h/%h st=%0d/%0d exp=0", nm, o8, o16, st8, st16);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(8, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(16, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    run_op(8, 1'b0, 16'd201, 16'd5, 16'd40, 16'd1, 1'b0, 1'b0, "u201_5");
  endtask

  task automatic test_signed();
    run_op(8, 1'b1, 16'hF9, 16'h02, 16'hFD, 16'hFF, 1'b0, 1'b0, "s-7_2");
    run_op(8, 1'b1, 16'h07, 16'hFE, 16'hFD, 16'h01, 1'b0, 1'b0, "s7_-2");
  endtask

  task automatic test_div_zero();
    run_op(8, 1'b0, 16'd37, 16'd0, 16'hFF, 16'd37, 1'b1, 1'b0, "u37_0");
    run_op(8, 1'b1, 16'hF0, 16'd0, 16'hFF, 16'hF0, 1'b1, 1'b0, "s-16_0");
  endtask

  task automatic test_overflow();
    run_op(8, 1'b1, 16'h80, 16'hFF, 16'h80, 16'h00, 1'b0, 1'b1, "s_min_m1");
    run_op(8, 1'b0, 16'h80, 16'hFF, 16'h00, 16'h80, 1'b0, 1'b0, "u_80_ff");
  endtask

  task automatic test_ignore_busy();
    int cnt, lat;
    @(negedge clk); drive(8, 1'b1, 1'b0, 16'd100, 16'd7);
    @(negedge clk); drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    @(negedge clk); drive(8, 1'b1, 1'b0, 16'd50, 16'd3);
    @(negedge clk); drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
    lat = 0;
    for (int k = 4; k <= 40; k++) begin
      if (dif8.done) begin lat = k; break; end
      @(negedge clk);
    end
    checks++;
    if (lat !== 10) begin failures++; $display("FAIL ignore_busy latency got=%0d exp=10", lat); end
    checks++;
    if (dif8.quotient !== 8'd14 || dif8.remainder !== 8'd2) begin
      failures++; $display("FAIL ignore_busy result got=%0d/%0d exp=14/2", dif8.quotient, dif8.remainder);
    end
    cnt = 0;
    repeat (15) begin @(negedge clk); if (dif8.done) cnt++; end
    checks++;
    if (cnt !== 0) begin failures++; $display("FAIL ignore_busy extra_done got=%0d exp=0", cnt); end
  endtask

  task automatic test_reset_mid_op();
    int cnt;
    @(negedge clk); drive(8, 1'b1, 1'b0, 16'd100, 16'd7);
    @(negedge clk); drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    @(negedge clk); drive(8, 1'b1, 1'b0, 16'd50, 16'd3);
    @(negedge clk); drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_cleared("reset_mid");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (15) begin @(negedge clk); if (dif8.done || dif8.busy) cnt++; end
    checks++;
    if (cnt !== 0) begin failures++; $display("FAIL reset_mid activity got=%0d exp=0", cnt); end
    run_op(8, 1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int gap;
    bit got;
    @(negedge clk); drive(8, 1'b1, 1'b0, 16'd201, 16'd5);
    @(negedge clk); drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
    got = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (dif8.done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got || dif8.quotient !== 8'd40) begin
      failures++; $display("FAIL b2b first got=%0d/%0b exp=40/1", dif8.quotient, got);
    end
    drive(8, 1'b1, 1'b0, 16'd100, 16'd7);
    @(negedge clk); drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
    gap = 0;
    for (int k = 1; k <= 40; k++) begin
      if (dif8.done) begin gap = k; break; end
      @(negedge clk);
    end
    checks++;
    if (gap !== 10) begin failures++; $display("FAIL b2b gap got=%0d exp=10", gap); end
    checks++;
    if (dif8.quotient !== 8'd14 || dif8.remainder !== 8'd2) begin
      failures++; $display("FAIL b2b second got=%0d/%0d exp=14/2", dif8.quotient, dif8.remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_wide();
    run_op(16, 1'b0, 16'hFFFF, 16'd255, 16'd257, 16'd0, 1'b0, 1'b0, "w65535_255");
  endtask

  task automatic test_random(input int w, input int n);
    logic [15:0] a, b, q, r;
    bit sm, dz, ov;
    int sel;
    logic [15:0] top;
    top = (w == 8) ? 16'h00FF : 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      sm  = 1'($urandom_range(0, 1));
      a   = 16'($urandom_range(0, int'(top)));
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 16'h0;
      else if (sel == 1) begin a = (w == 8) ? 16'h0080 : 16'h8000; b = top; end
      else b = 16'($urandom_range(1, int'(top)));
      model(w, sm, a, b, q, r, dz, ov);
      run_op(w, sm, a, b, q, r, dz, ov, $sformatf("rand%0d_%0d", w, i));
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore_busy();
    test_reset_mid_op();
    test_back_to_back();
    test_wide();
    test_random(8, 40);
    test_random(16, 20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
